cp0_exc_ctrl: RTL and testbench

- Coprocessor-0 exception/interrupt controller, placed at the M stage of the 5-stage MIPS pipeline.
- Consumes the exception code, branch-delay flag and PC carried down the pipeline registers, plus the external hardware interrupt lines.
- Produces the single-cycle `Req` pulse that flushes the pipeline registers and redirects fetch to the handler.
- Holds SR, Cause, EPC and PRId, serving mfc0/mtc0/eret.

---
 rtl/cp0_exc_ctrl.sv | 110 +++++++++++
 tb/tb_cp0_exc_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller at the M stage.
// Holds SR, Cause, EPC and PRId; raises Req to flush the pipeline and enter the handler.
module cp0_exc_ctrl #(
    parameter logic [31:0] PRID_VALUE = 32'h0000_4341
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  CP0Add,
    input  logic [31:0] CP0In,
    output logic [31:0] CP0Out,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] EPCOut,
    output logic        Req
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    // SR fields
    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    // Cause fields
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exc_code;
    // EPC
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic        w_req;
    logic        w_sr_wr;
    logic        w_epc_wr;
    logic [31:0] w_pc_aligned;
    logic [31:0] w_epc_next;
    logic [4:0]  w_exc_code_next;
    logic [31:0] w_sr_word;
    logic [31:0] w_cause_word;

    // EXL masks both sources so a handler is never re-entered before eret.
    assign w_int_req = (|(HWInt & r_im)) & r_ie & ~r_exl;
    assign w_exc_req = (ExcCodeIn != 5'd0) & ~r_exl;
    assign w_req     = reset & (w_int_req | w_exc_req);
    assign Req       = w_req;

    assign w_pc_aligned    = {VPC[31:2], 2'b00};
    assign w_epc_next      = BDIn ? (w_pc_aligned - 32'd4) : w_pc_aligned;
    assign w_exc_code_next = w_int_req ? 5'd0 : ExcCodeIn;

    // A taken exception drops any same-cycle mtc0.
    assign w_sr_wr  = en & ~w_req & (CP0Add == ADDR_SR);
    assign w_epc_wr = en & ~w_req & (CP0Add == ADDR_EPC);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_im       <= 6'd0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ip       <= 6'd0;
            r_exc_code <= 5'd0;
            r_epc      <= 32'd0;
        end else begin
            r_ip <= HWInt;
            if (w_req) begin
                r_exl      <= 1'b1;
                r_bd       <= BDIn;
                r_exc_code <= w_exc_code_next;
                r_epc      <= w_epc_next;
            end else begin
                if (w_sr_wr) begin
                    r_im  <= CP0In[15:10];
                    r_exl <= CP0In[1];
                    r_ie  <= CP0In[0];
                end else if (EXLClr) begin
                    r_exl <= 1'b0;
                end
                if (w_epc_wr) begin
                    r_epc <= CP0In;
                end
            end
        end
    end

    assign w_sr_word    = {16'd0, r_im, 8'd0, r_exl, r_ie};
    assign w_cause_word = {r_bd, 15'd0, r_ip, 3'd0, r_exc_code, 2'b00};

    always_comb begin
        CP0Out = 32'd0;
        unique case (CP0Add)
            ADDR_SR:    CP0Out = w_sr_word;
            ADDR_CAUSE: CP0Out = w_cause_word;
            ADDR_EPC:   CP0Out = r_epc;
            ADDR_PRID:  CP0Out = PRID_VALUE;
            default:    CP0Out = 32'd0;
        endcase
    end

    // eret redirect sees the committed EPC only; the hazard unit orders mtc0 before eret.
    assign EPCOut = r_epc;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed vector table, then random stimulus
// compared against a word-level model of the CP0 registers.
module tb_cp0_exc_ctrl;

    logic        clk;
    logic        reset;
    logic        en;
    logic [4:0]  CP0Add;
    logic [31:0] CP0In;
    logic [31:0] CP0Out;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] EPCOut;
    logic        Req;

    int n_checks = 0;
    int n_errors = 0;

    cp0_exc_ctrl #(.PRID_VALUE(32'h0000_4341)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .CP0Add    (CP0Add),
        .CP0In     (CP0In),
        .CP0Out    (CP0Out),
        .VPC       (VPC),
        .BDIn      (BDIn),
        .ExcCodeIn (ExcCodeIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .EPCOut    (EPCOut),
        .Req       (Req)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        en;
        logic [4:0]  add;
        logic [31:0] din;
        logic [31:0] vpc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        eret;
        logic        req;
        logic [31:0] out;
        logic [31:0] epc;
        logic        chk_epc;
    } vec_t;

    vec_t tv[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        reset     = v.rst;
        en        = v.en;
        CP0Add    = v.add;
        CP0In     = v.din;
        VPC       = v.vpc;
        BDIn      = v.bd;
        ExcCodeIn = v.exc;
        HWInt     = v.hw;
        EXLClr    = v.eret;
    endtask

    // Reference model: architectural register words.
    logic [31:0] m_sr, m_cause, m_epc;

    function automatic logic m_int_req();
        return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_req();
        return reset && (m_int_req() || (ExcCodeIn != 5'd0 && !m_sr[1]));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h0000_4341;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_clock();
        logic [31:0] pc;
        logic        take;
        logic        irq;
        take = m_req();
        irq  = m_int_req();
        if (!reset) begin
            m_sr = 0; m_cause = 0; m_epc = 0;
        end else if (take) begin
            pc      = VPC & ~32'd3;
            m_sr    = m_sr | 32'd2;
            m_epc   = BDIn ? pc - 4 : pc;
            m_cause = ({31'd0, BDIn} << 31) | ({26'd0, HWInt} << 10)
                    | ((irq ? 32'd0 : {27'd0, ExcCodeIn}) << 2);
        end else begin
            if (en && CP0Add == 5'd12) m_sr = CP0In & 32'h0000_FC03;
            else if (EXLClr)           m_sr = m_sr & ~32'd2;
            if (en && CP0Add == 5'd14) m_epc = CP0In;
            m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, HWInt} << 10);
        end
    endtask

    initial begin
        vec_t v;
        drive('{1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0,
                1'b0, 32'd0, 32'd0, 1'b0});

        // rst en add din vpc bd exc hw eret | req out epc chk_epc
        tv.push_back('{1'b0,1'b0,5'd15,32'd0,32'd0,1'b0,5'd4,6'h3F,1'b0, 1'b0,32'h4341,32'd0,1'b0});
        tv.push_back('{1'b0,1'b0,5'd12,32'd0,32'd0,1'b0,5'd4,6'h3F,1'b0, 1'b0,32'd0,32'd0,1'b1});
        tv.push_back('{1'b1,1'b0,5'd13,32'd0,32'd0,1'b0,5'd0,6'h00,1'b0, 1'b0,32'd0,32'd0,1'b1});
        tv.push_back('{1'b1,1'b0,5'd14,32'd0,32'd0,1'b0,5'd0,6'h00,1'b0, 1'b0,32'd0,32'd0,1'b1});
        tv.push_back('{1'b1,1'b1,5'd12,32'h401,32'd0,1'b0,5'd0,6'h00,1'b0, 1'b0,32'd0,32'd0,1'b1});
        tv.push_back('{1'b1,1'b0,5'd12,32'd0,32'h3010,1'b0,5'd0,6'h01,1'b0, 1'b1,32'h401,32'd0,1'b1});
        tv.push_back('{1'b1,1'b0,5'd13,32'd0,32'd0,1'b0,5'd0,6'h01,1'b0, 1'b0,32'h400,32'h3010,1'b1});
        tv.push_back('{1'b1,1'b0,5'd12,32'd0,32'd0,1'b0,5'd0,6'h01,1'b0, 1'b0,32'h403,32'h3010,1'b1});
        tv.push_back('{1'b1,1'b0,5'd14,32'd0,32'd0,1'b0,5'd0,6'h00,1'b0, 1'b0,32'h3010,32'h3010,1'b1});
        tv.push_back('{1'b1,1'b1,5'd12,32'd0,32'd0,1'b0,5'd0,6'h00,1'b0, 1'b0,32'h403,32'h3010,1'b1});
        tv.push_back('{1'b1,1'b0,5'd12,32'd0,32'h3024,1'b1,5'd10,6'h00,1'b0, 1'b1,32'd0,32'h3010,1'b1});
        tv.push_back('{1'b1,1'b0,5'd13,32'd0,32'd0,1'b0,5'd4,6'h00,1'b0, 1'b0,32'h8000_0028,32'h3020,1'b1});
        tv.push_back('{1'b1,1'b0,5'd13,32'd0,32'd0,1'b0,5'd4,6'h00,1'b1, 1'b0,32'h8000_0028,32'h3020,1'b1});
        tv.push_back('{1'b1,1'b0,5'd12,32'd0,32'h3040,1'b0,5'd4,6'h00,1'b0, 1'b1,32'd0,32'h3020,1'b1});
        tv.push_back('{1'b1,1'b1,5'd12,32'd0,32'd0,1'b0,5'd0,6'h00,1'b0, 1'b0,32'h2,32'h3040,1'b1});
        tv.push_back('{1'b1,1'b1,5'd14,32'h5000,32'h3100,1'b0,5'd12,6'h00,1'b0, 1'b1,32'h3040,32'h3040,1'b1});
        tv.push_back('{1'b1,1'b0,5'd14,32'd0,32'd0,1'b0,5'd0,6'h00,1'b0, 1'b0,32'h3100,32'h3100,1'b1});
        tv.push_back('{1'b1,1'b1,5'd13,32'hFFFF_FFFF,32'd0,1'b0,5'd0,6'h2A,1'b0, 1'b0,32'h30,32'h3100,1'b1});
        tv.push_back('{1'b1,1'b0,5'd13,32'd0,32'd0,1'b0,5'd0,6'h2A,1'b0, 1'b0,32'hA830,32'h3100,1'b1});
        tv.push_back('{1'b1,1'b1,5'd12,32'hFC01,32'd0,1'b0,5'd0,6'h2A,1'b0, 1'b0,32'h2,32'h3100,1'b1});
        tv.push_back('{1'b1,1'b0,5'd12,32'd0,32'h3200,1'b0,5'd8,6'h2A,1'b0, 1'b1,32'hFC01,32'h3100,1'b1});
        tv.push_back('{1'b1,1'b0,5'd13,32'd0,32'd0,1'b0,5'd0,6'h2A,1'b0, 1'b0,32'hA800,32'h3200,1'b1});
        tv.push_back('{1'b1,1'b1,5'd12,32'hFC01,32'd0,1'b0,5'd0,6'h00,1'b0, 1'b0,32'hFC03,32'h3200,1'b1});
        tv.push_back('{1'b1,1'b0,5'd12,32'd0,32'h3300,1'b0,5'd3,6'h00,1'b1, 1'b1,32'hFC01,32'h3200,1'b1});
        tv.push_back('{1'b1,1'b0,5'd12,32'd0,32'd0,1'b0,5'd0,6'h00,1'b0, 1'b0,32'hFC03,32'h3300,1'b1});
        tv.push_back('{1'b0,1'b0,5'd12,32'd0,32'd0,1'b0,5'd5,6'h3F,1'b0, 1'b0,32'hFC03,32'h3300,1'b1});
        tv.push_back('{1'b1,1'b0,5'd12,32'd0,32'd0,1'b0,5'd0,6'h3F,1'b0, 1'b0,32'd0,32'd0,1'b1});
        tv.push_back('{1'b1,1'b0,5'd14,32'd0,32'h3007,1'b1,5'd2,6'h00,1'b0, 1'b1,32'd0,32'd0,1'b1});
        tv.push_back('{1'b1,1'b0,5'd14,32'd0,32'd0,1'b0,5'd0,6'h00,1'b0, 1'b0,32'h3000,32'h3000,1'b1});

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            drive(tv[i]);
            #1;
            check($sformatf("vec%0d Req", i), {31'd0, Req}, {31'd0, tv[i].req});
            check($sformatf("vec%0d CP0Out[%0d]", i, tv[i].add), CP0Out, tv[i].out);
            if (tv[i].chk_epc) check($sformatf("vec%0d EPCOut", i), EPCOut, tv[i].epc);
        end

        // Random phase: start both DUT and model from reset.
        @(negedge clk);
        v = tv[0];
        drive(v);
        @(posedge clk);
        m_sr = 0; m_cause = 0; m_epc = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            reset     = ($urandom_range(31, 0) != 0);
            en        = ($urandom_range(3, 0) == 0);
            CP0Add    = 5'($urandom_range(17, 10));
            CP0In     = $urandom;
            VPC       = $urandom;
            BDIn      = 1'($urandom_range(1, 0));
            ExcCodeIn = ($urandom_range(3, 0) == 0) ? 5'($urandom_range(31, 1)) : 5'd0;
            HWInt     = ($urandom_range(1, 0) == 0) ? 6'd0 : 6'($urandom);
            EXLClr    = !en && ($urandom_range(5, 0) == 0);
            #1;
            check("rand Req", {31'd0, Req}, {31'd0, m_req()});
            check($sformatf("rand CP0Out[%0d]", CP0Add), CP0Out, m_read(CP0Add));
            check("rand EPCOut", EPCOut, m_epc);
            @(posedge clk);
            m_clock();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
